// File: rtl/lane_seq_mux_pkg.sv
`default_nettype none
// ============================================================================
// lane_seq_pkg : state encoding and index/slice helpers for limb sequencers
// Rev 1.0
// ============================================================================
package lane_seq_pkg;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Low bit of lane k in a flattened bus of w-bit lanes.
   function automatic int lane_lo(input int k, input int w);
      return k * w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lane_seq_mux_prio_enc.sv
`default_nettype none
// ============================================================================
// prio_enc_msb : mask -> index of highest set bit, any-set and single-bit flags
// Rev 1.0
// ============================================================================
module prio_enc_msb
   import lane_seq_pkg::*;
#(
   parameter int N  = 8,
   parameter int IW = idx_width(N)
) (
   input  logic [N-1:0]  i_mask,
   output logic [IW-1:0] o_idx,
   output logic          o_any,
   output logic          o_single
);

   localparam logic [N-1:0] c_ONE = {{(N-1){1'b0}}, 1'b1};

   always_comb begin
      o_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (i_mask[i]) o_idx = IW'(i);
      end
      o_any    = |i_mask;
      // Clearing the lowest set bit leaves zero only when a single bit was set.
      o_single = o_any && ((i_mask & (i_mask - c_ONE)) == '0);
   end

endmodule
`default_nettype wire

// File: rtl/lane_seq_mux.sv
`default_nettype none
// ============================================================================
// lane_seq_mux : captures a wide operand and streams selected lanes, MSB first
// Rev 1.0
// ============================================================================
module lane_seq_mux
   import lane_seq_pkg::*;
#(
   parameter  int LANES  = 8,
   parameter  int LANE_W = 64,
   parameter  int SUB_W  = 8,
   localparam int IDX_W  = idx_width(LANES)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*LANE_W-1:0] iA,
   input  logic [LANES*SUB_W-1:0]  iA_sub,
   input  logic [LANES-1:0]        sel,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANE_W-1:0]       oA,
   output logic [SUB_W-1:0]        oA_sub,
   output logic [IDX_W-1:0]        out_idx,
   output logic                    out_last,
   output logic                    out_none
);

   localparam logic [LANES-1:0] c_ONE = {{(LANES-1){1'b0}}, 1'b1};

   logic [0:0]              r_state;
   logic [0:0]              w_state_nxt;
   logic [LANES*LANE_W-1:0] r_opr;
   logic [LANES*SUB_W-1:0]  r_sub;
   logic [LANES-1:0]        r_mask;
   logic [IDX_W-1:0]        w_idx;
   logic                    w_any;
   logic                    w_single;
   logic [LANES-1:0]        w_clr;

   prio_enc_msb #(.N(LANES), .IW(IDX_W)) u_enc (
      .i_mask   (r_mask),
      .o_idx    (w_idx),
      .o_any    (w_any),
      .o_single (w_single)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (in_valid)              w_state_nxt = ST_RUN;
         ST_RUN:  if (out_ready && out_last) w_state_nxt = ST_IDLE;
         default:                            w_state_nxt = ST_IDLE;
      endcase
   end

   // An empty mask in RUN is the single empty-command beat for a sel==0 command.
   always_comb begin
      in_ready  = (r_state == ST_IDLE);
      out_valid = (r_state == ST_RUN);
      out_none  = out_valid & ~w_any;
      out_last  = out_valid & (w_single | ~w_any);
      out_idx   = w_idx;
      oA        = w_any ? r_opr[lane_lo(int'(w_idx), LANE_W) +: LANE_W] : '0;
      oA_sub    = w_any ? r_sub[lane_lo(int'(w_idx), SUB_W) +: SUB_W]   : '0;
   end

   assign w_clr = c_ONE << w_idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_opr  <= '0;
         r_sub  <= '0;
         r_mask <= '0;
      end else if (r_state == ST_IDLE && in_valid) begin
         r_opr  <= iA;
         r_sub  <= iA_sub;
         r_mask <= sel;
      end else if (r_state == ST_RUN && out_ready) begin
         r_mask <= r_mask & ~w_clr;
      end
   end

endmodule
`default_nettype wire
